// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default constants for the UART TX arbiter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
    localparam int UART_BYTE_W      = 8;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_LOCK_TIMEOUT = 1024;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_valid
);
    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        winner    = ptr;
        any_valid = |req;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) winner = W'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter.
// Define UART_ARB_LOCK_TIMEOUT_EN to drop a stalled lock after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int GID_W        = $clog2(NUM_REQ),
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [GID_W-1:0]               grant_id,
    output logic                           active,
    output logic                           lock_abort
);
    state_t                 state, state_nx;
    logic                   locked, locked_nx, any_valid, sel_valid, sel_last, abort;
    logic [GID_W-1:0]       rr_ptr, rr_ptr_nx, grant_nx, winner, next_id;
    logic [UART_BYTE_W-1:0] data_q, sel_data;
    logic [UART_BYTE_W-1:0] bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign bytes[g] = req_data[g*UART_BYTE_W +: UART_BYTE_W];
    end

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = bytes[grant_id];
    assign next_id   = (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + GID_W'(1);

    rr_pick #(.N(NUM_REQ), .W(GID_W)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The byte is shown live during SEND so the transmitter can load it with tx_start.
    assign tx_start  = state == SEND;
    assign tx_data   = tx_start ? sel_data : data_q;
    assign req_ready = tx_start ? NUM_REQ'(1) << grant_id : '0;
    assign active    = state != IDLE || locked;

    always_comb begin
        state_nx  = state;
        locked_nx = locked;
        rr_ptr_nx = rr_ptr;
        grant_nx  = grant_id;
        case (state)
            IDLE: begin
                if (locked) begin
                    if (sel_valid) state_nx = SEND;
                end else if (any_valid) begin
                    grant_nx  = winner;
                    locked_nx = 1'b1;
                    state_nx  = SEND;
                end
            end
            SEND: begin
                state_nx = WAIT_BUSY;
                if (sel_last) begin
                    locked_nx = 1'b0;
                    rr_ptr_nx = next_id;
                end
            end
            WAIT_BUSY: state_nx = tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_nx = tx_busy ? WAIT_DONE : IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort) begin
            locked_nx = 1'b0;
            rr_ptr_nx = next_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            locked   <= 1'b0;
            rr_ptr   <= '0;
            grant_id <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nx;
            locked   <= locked_nx;
            rr_ptr   <= rr_ptr_nx;
            grant_id <= grant_nx;
            data_q   <= tx_start ? sel_data : data_q;
        end
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        stall;

    assign stall = state == IDLE && locked && !sel_valid;
    assign abort = stall && idle_cnt == 16'(LOCK_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt   <= '0;
            lock_abort <= 1'b0;
        end else begin
            lock_abort <= abort;
            idle_cnt   <= (tx_start || sel_valid || abort) ? '0 : stall ? idle_cnt + 16'd1 : idle_cnt;
        end
    end
`else
    assign abort      = 1'b0;
    assign lock_abort = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven single-byte vectors plus directed multi-cycle sequences.
module tb_uart_tx_arbiter;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    localparam int LT = 20;
`else
    localparam int LT = 1024;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, tx_start, tx_busy, active, lock_abort;
    logic [3:0]  req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;

    uart_tx_arbiter #(.NUM_REQ(4), .GID_W(2), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .lock_abort(lock_abort)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Transmitter model: busy rises bdly cycles after the start edge and lasts blen cycles.
    int bdly = 0, blen = 10, pc = 1000;
    always @(posedge clk) pc <= tx_start ? 0 : (pc < 1000 ? pc + 1 : pc);
    assign tx_busy = pc >= bdly && pc < bdly + blen;

    // Requester models: per-requester byte queues {last, data}, presented in order.
    logic [8:0] pkt [4][16];
    int cnt [4] = '{default: 0};
    int pos [4] = '{default: 0};
    bit drv_en = 0;
    always @(posedge clk) begin
        if (drv_en) begin
            for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) pos[i]++;
            #1;
            for (int i = 0; i < 4; i++) begin
                req_valid[i]      = pos[i] < cnt[i];
                req_data[8*i +: 8] = pos[i] < cnt[i] ? pkt[i][pos[i]][7:0] : 8'h00;
                req_last[i]       = pos[i] < cnt[i] ? pkt[i][pos[i]][8] : 1'b0;
            end
        end
    end

    task automatic load(input int i, input logic [7:0] b, input logic l);
        pkt[i][cnt[i]] = {l, b};
        cnt[i]++;
    endtask

    // Monitor: logs every start and flags restarts or data changes inside a busy window.
    int nlog = 0, cyc = 0, start_viol = 0, data_viol = 0, abort_cnt = 0, abort_cyc = 0;
    logic [1:0] log_gid [64];
    logic [7:0] log_data [64];
    logic [3:0] log_rdy [64];
    int         log_cyc [64];
    bit pending = 0, seen_busy = 0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pending   = 0;
            seen_busy = 0;
        end else begin
            if (tx_start) begin
                if (pending) start_viol++;
                if (nlog < 64) begin
                    log_gid[nlog] = grant_id; log_data[nlog] = tx_data;
                    log_rdy[nlog] = req_ready; log_cyc[nlog] = cyc;
                end
                nlog++;
                pending = 1; seen_busy = 0; held = tx_data;
            end else if (pending) begin
                if (tx_data != held) data_viol++;
                if (tx_busy) seen_busy = 1;
                else if (seen_busy) pending = 0;
            end
            if (lock_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
        end
    end

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (nlog < n && k < 300) begin
            at_neg();
            k++;
        end
        if (nlog < n) check(name, nlog, n);
    endtask

    task automatic do_reset();
        at_neg();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; pos[i] = 0; end
        repeat (16) at_neg();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  gid;
        logic [7:0]  byt;
        logic [3:0]  rdy;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int base, k;
        tbl[0] = '{4'b0100, 32'h3341_1100, 2'd2, 8'h41, 4'b0100};
        tbl[1] = '{4'b0101, 32'h0077_005A, 2'd0, 8'h5A, 4'b0001};
        tbl[2] = '{4'b1111, 32'hD4C3_B2A1, 2'd1, 8'hB2, 4'b0010};
        tbl[3] = '{4'b0011, 32'h0000_6699, 2'd0, 8'h99, 4'b0001};
        tbl[4] = '{4'b1000, 32'hF000_0000, 2'd3, 8'hF0, 4'b1000};
        tbl[5] = '{4'b1100, 32'h1234_0000, 2'd2, 8'h34, 4'b0100};
        tbl[6] = '{4'b1110, 32'hABCD_EF00, 2'd3, 8'hAB, 4'b1000};

        #3;
        check("rst_ready", req_ready, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_gid", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_abort", lock_abort, 0);
        repeat (3) at_neg();
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            @(posedge clk);
            #1;
            req_valid = tbl[v].valid; req_data = tbl[v].data; req_last = tbl[v].valid;
            at_neg();
            check($sformatf("v%0d_lat", v), tx_start, 0);
            at_neg();
            check($sformatf("v%0d_start", v), tx_start, 1);
            check($sformatf("v%0d_gid", v), grant_id, tbl[v].gid);
            check($sformatf("v%0d_data", v), tx_data, tbl[v].byt);
            check($sformatf("v%0d_ready", v), req_ready, tbl[v].rdy);
            @(posedge clk);
            #1;
            req_valid = '0;
            at_neg();
            check($sformatf("v%0d_pulse", v), {req_ready, tx_start}, 0);
            k = 1;
            while (active && k < 40) begin
                at_neg();
                k++;
            end
            check($sformatf("v%0d_idle_after", v), k, 12);
        end

        // Fairness under full load: grants rotate 0,1,2,3,0,1.
        drv_en = 1;
        bdly = 1; blen = 4;
        do_reset();
        base = nlog;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 6; b++) load(i, 8'(i * 16 + b + 1), 1'b1);
        wait_log(base + 6, "fair_timeout");
        for (int e = 0; e < 6; e++) begin
            check($sformatf("fair%0d_gid", e), log_gid[base+e], e % 4);
            check($sformatf("fair%0d_data", e), log_data[base+e], 8'((e % 4) * 16 + e / 4 + 1));
            check($sformatf("fair%0d_ready", e), log_rdy[base+e], 4'b0001 << (e % 4));
        end
        check("fair_restart", start_viol, 0);

        // Packet lock: req1's packet goes out whole before req0 is served again.
        bdly = 0; blen = 3;
        do_reset();
        base = nlog;
        load(0, 8'h01, 1'b1); load(0, 8'hA0, 1'b1);
        load(1, 8'h10, 1'b0); load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
        wait_log(base + 5, "lock_timeout");
        check("lock0", {log_gid[base], log_data[base]}, {2'd0, 8'h01});
        check("lock1", {log_gid[base+1], log_data[base+1]}, {2'd1, 8'h10});
        check("lock2", {log_gid[base+2], log_data[base+2]}, {2'd1, 8'h11});
        check("lock3", {log_gid[base+3], log_data[base+3]}, {2'd1, 8'h12});
        check("lock4", {log_gid[base+4], log_data[base+4]}, {2'd0, 8'hA0});
        check("lock_b2b", log_cyc[base+2] - log_cyc[base+1], 6);

        // Busy rising late: the next byte waits for the full busy window.
        bdly = 3; blen = 5;
        do_reset();
        base = nlog;
        load(3, 8'h31, 1'b0); load(3, 8'h32, 1'b1);
        wait_log(base + 2, "busy_timeout");
        check("busy_d0", log_data[base], 8'h31);
        check("busy_d1", log_data[base+1], 8'h32);
        check("busy_gap", log_cyc[base+1] - log_cyc[base], 11);
        check("busy_restart", start_viol, 0);
        check("busy_hold", data_viol, 0);

        // Stalled lock: requester 0 stops mid-packet while requester 1 waits.
        bdly = 0; blen = 3;
        do_reset();
        base = nlog;
        abort_cnt = 0;
        load(0, 8'h55, 1'b0); load(1, 8'h66, 1'b1);
        wait_log(base + 1, "stall_timeout");
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        k = 0;
        while (abort_cnt == 0 && k < 80) begin at_neg(); k++; end
        check("abort_seen", abort_cnt, 1);
        check("abort_time", abort_cyc - log_cyc[base], 25);
        wait_log(base + 2, "abort_grant_timeout");
        check("abort_gid", {log_gid[base+1], log_data[base+1]}, {2'd1, 8'h66});
        check("abort_grant_time", log_cyc[base+1] - log_cyc[base], 26);
        repeat (3) at_neg();
        check("abort_pulse", abort_cnt, 1);
`else
        repeat (60) at_neg();
        check("stall_starve", nlog - base, 1);
        check("stall_active", active, 1);
        check("stall_gid", grant_id, 0);
        check("stall_no_abort", abort_cnt, 0);
        load(0, 8'h56, 1'b1);
        wait_log(base + 3, "resume_timeout");
        check("resume0", {log_gid[base+1], log_data[base+1]}, {2'd0, 8'h56});
        check("resume1", {log_gid[base+2], log_data[base+2]}, {2'd1, 8'h66});
`endif

        // Reset during WAIT_DONE of byte 2 of 4, then a fresh grant to req3.
        bdly = 0; blen = 6;
        do_reset();
        base = nlog;
        load(1, 8'h81, 1'b0); load(1, 8'h82, 1'b0); load(1, 8'h83, 1'b0); load(1, 8'h84, 1'b1);
        wait_log(base + 2, "mid_timeout");
        at_neg();
        at_neg();
        check("mid_pre_active", active, 1);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; pos[i] = 0; end
        #1;
        check("mid_ready", req_ready, 0);
        check("mid_start", tx_start, 0);
        check("mid_data", tx_data, 0);
        check("mid_gid", grant_id, 0);
        check("mid_active", active, 0);
        check("mid_abort", lock_abort, 0);
        repeat (16) at_neg();
        rst_n = 1'b1;
        base = nlog;
        load(3, 8'h77, 1'b1);
        wait_log(base + 1, "post_timeout");
        check("post_grant", {log_gid[base], log_data[base], log_rdy[base]}, {2'd3, 8'h77, 4'b1000});
        check("data_stable", data_viol, 0);
        check("no_restart", start_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
